// File: rtl/wb_board_arbiter_pkg.sv
// Shared types and constants for the game-board Wishbone arbiter.
//   arb_state_t       : arbiter FSM states
//   BOARD_ARB_TIMEOUT : default watchdog limit (cycles stb may wait for ack)
package wb_board_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int BOARD_ARB_TIMEOUT = 64;

endpackage

// File: rtl/wb_board_arbiter_if.sv
// Bus bundle between the game masters, the arbiter and the board memory.
//   m_* : N packed master-side Wishbone signals (master i at slice i)
//   s_* : single slave-side Wishbone port towards game_board_mem
// Modports:
//   master : the environment (masters plus memory) driving requests and slave replies
//   slave  : the arbiter, consuming requests and driving the shared slave port
interface wb_board_arbiter_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) ();

  logic [N_MASTERS-1:0]        m_cyc;
  logic [N_MASTERS-1:0]        m_stb;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_adr;
  logic [N_MASTERS*DATA_W-1:0] m_dat_w;
  logic [DATA_W-1:0]           m_dat_r;
  logic [N_MASTERS-1:0]        m_ack;
  logic [N_MASTERS-1:0]        m_err;

  logic                        s_cyc;
  logic                        s_stb;
  logic                        s_we;
  logic [ADDR_W-1:0]           s_adr;
  logic [DATA_W-1:0]           s_dat_w;
  logic [DATA_W-1:0]           s_dat_r;
  logic                        s_ack;

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack,
    input  m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w
  );

  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, s_dat_r, s_ack,
    output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w
  );

endinterface

// File: rtl/wb_board_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req      in  : per-master request vector
//   last_idx in  : index of the master served most recently
//   gnt      out : one-hot first requester found scanning upward from last_idx+1 (wraps mod N)
//   gnt_idx  out : binary index of gnt
//   valid    out : at least one request present
module rr_picker
  import wb_board_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_idx,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 valid
);

  localparam int IDX_W = $clog2(N);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // scan candidates last_idx+1 .. last_idx+N; wrap is mod N so non-power-of-2 counts work
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(last_idx) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_board_arbiter.sv
// Round-robin arbiter sharing the board-memory Wishbone slave between N masters.
// The owner keeps the bus for its whole cyc; a watchdog forces release when stb waits
// TIMEOUT_CYC cycles without ack, signalling a 1-cycle m_err to the owner.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport (m_* from masters, s_* towards memory)
//   grant      : one-hot current owner
module wb_board_arbiter
  import wb_board_arbiter_pkg::*;
#(
  parameter int N_MASTERS   = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = BOARD_ARB_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_board_arbiter_if.slave    bus,
  output logic [N_MASTERS-1:0] grant
);

  localparam int               IDX_W      = $clog2(N_MASTERS);
  localparam int               WDOG_W     = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_MASTERS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;
  localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);

  arb_state_t           r_state,    w_state_nxt;
  logic [N_MASTERS-1:0] r_grant,    w_grant_nxt;
  logic [N_MASTERS-1:0] r_err,      w_err_nxt;
  logic [IDX_W-1:0]     r_owner,    w_owner_nxt;
  logic [IDX_W-1:0]     r_last_idx, w_last_idx_nxt;
  logic [WDOG_W-1:0]    r_wdog,     w_wdog_nxt;

  logic [N_MASTERS-1:0] w_pick_gnt;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_owner_cyc;
  logic                 w_stall;

  logic                 w_s_cyc, w_s_stb, w_s_we;
  logic [ADDR_W-1:0]    w_s_adr;
  logic [DATA_W-1:0]    w_s_dat_w;

  rr_picker #(.N(N_MASTERS)) u_picker (
    .req      (bus.m_cyc),
    .last_idx (r_last_idx),
    .gnt      (w_pick_gnt),
    .gnt_idx  (w_pick_idx),
    .valid    (w_pick_valid)
  );

  // one-hot AND-OR mux of the owner onto the slave port; all zero when nobody holds grant
  always_comb begin
    w_s_cyc   = 1'b0;
    w_s_stb   = 1'b0;
    w_s_we    = 1'b0;
    w_s_adr   = '0;
    w_s_dat_w = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_s_cyc   = w_s_cyc | (r_grant[i] & bus.m_cyc[i]);
      w_s_stb   = w_s_stb | (r_grant[i] & bus.m_stb[i]);
      w_s_we    = w_s_we  | (r_grant[i] & bus.m_we[i]);
      w_s_adr   = w_s_adr   | ({ADDR_W{r_grant[i]}} & bus.m_adr[i*ADDR_W +: ADDR_W]);
      w_s_dat_w = w_s_dat_w | ({DATA_W{r_grant[i]}} & bus.m_dat_w[i*DATA_W +: DATA_W]);
    end
  end

  assign bus.s_cyc   = w_s_cyc;
  assign bus.s_stb   = w_s_stb;
  assign bus.s_we    = w_s_we;
  assign bus.s_adr   = w_s_adr;
  assign bus.s_dat_w = w_s_dat_w;
  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.m_ack   = {N_MASTERS{bus.s_ack}} & r_grant;
  assign bus.m_err   = r_err;
  assign grant       = r_grant;

  assign w_owner_cyc = |(bus.m_cyc & r_grant);
  assign w_stall     = w_s_stb & ~bus.s_ack;

  // next-state, grant, watchdog and error decode
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_last_idx_nxt = r_last_idx;
    w_err_nxt      = '0;
    // watchdog counts stalled strobes only and saturates; outside BUSY s_stb is 0 so it clears
    if (w_stall) begin
      w_wdog_nxt = (r_wdog == WDOG_MAX) ? r_wdog : r_wdog + WDOG_ONE;
    end else begin
      w_wdog_nxt = '0;
    end
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_gnt;
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ARB_BUSY;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        // a cyc drop wins over the watchdog; an ack in the limit cycle cancels the timeout
        if (!w_owner_cyc) begin
          w_grant_nxt    = '0;
          w_last_idx_nxt = r_owner;
          w_state_nxt    = ARB_RELEASE;
        end else if ((r_wdog == WDOG_LIMIT) && !bus.s_ack) begin
          w_err_nxt      = r_grant;
          w_grant_nxt    = '0;
          w_last_idx_nxt = r_owner;
          w_state_nxt    = ARB_RELEASE;
        end else begin
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_RELEASE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_wdog_nxt  = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // state, grant, watchdog and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_last_idx <= LAST_RST;
      r_wdog     <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_wdog     <= w_wdog_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
